ifs_align_ctrl: RTL and testbench

- Word-alignment controller for a single-bit input capture lane built from async-clear input registers (SCLK-clocked, CD-cleared).
- Drives the lane's CD clear, deserialises the registered bit stream into WIDTH-bit words, and hunts for a training pattern by bit-slipping the word boundary.
- Declares lock after repeated matches, then delivers payload words.
- Sits between the pad-side input register and the receive datapath.

---
 rtl/ifs_align_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_ifs_align_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ifs_align_ctrl.sv
// ---------------------------------------------------------------------------
// ifs_align_ctrl
//
// Word-alignment controller for a single-bit input capture lane. The lane is
// a pad-side input register clocked by SCLK with an async clear (CD). This
// block drives that clear, deserialises the registered bit stream into
// WIDTH-bit words, and hunts for a training pattern by slipping the word
// boundary one bit at a time. After LOCK_COUNT consecutive matching words it
// declares lock and then hands every assembled word to the receive datapath.
//
// Parameters:
//   WIDTH      word width in bits (>= 4)
//   PATTERN    WIDTH-bit training word, MSB received first
//   LOCK_COUNT consecutive matching words needed to declare lock (>= 1)
//   CLR_CYCLES cycles CD is held high while clearing (>= 1)
//
// Ports:
//   SCLK       clock, all state updates on the rising edge
//   RSTN       asynchronous active-low reset
//   START      single-cycle request to (re)start alignment
//   D          serial bit from the input register Q
//   CD         clear to the input register(s), active high
//   WORD       last assembled word (registered)
//   WORD_VALID one-cycle pulse, WORD holds new payload
//   LOCKED     alignment achieved
//   ERR        alignment failed after every bit phase was tried
// ---------------------------------------------------------------------------
module ifs_align_ctrl #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] PATTERN    = 8'hA5,
  parameter int               LOCK_COUNT = 4,
  parameter int               CLR_CYCLES = 2
) (
  input  logic             SCLK,
  input  logic             RSTN,
  input  logic             START,
  input  logic             D,
  output logic             CD,
  output logic [WIDTH-1:0] WORD,
  output logic             WORD_VALID,
  output logic             LOCKED,
  output logic             ERR
);

  localparam int BW = $clog2(WIDTH);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_HUNT,
    S_SLIP,
    S_CONFIRM,
    S_LOCK,
    S_FAIL
  } state_t;

  state_t           state;
  logic [WIDTH-2:0] sr;
  logic [BW-1:0]    bitcnt;
  logic [BW-1:0]    slipcnt;
  logic [MW-1:0]    matchcnt;
  logic [CW-1:0]    clrcnt;
  logic             skip;

  logic             boundary;
  logic [WIDTH-1:0] candidate;
  logic             is_match;
  logic             last_phase;

  // The candidate word includes the bit arriving this cycle, so a word is
  // complete on the cycle where the bit counter sits at WIDTH-1. Running out
  // of phases is judged on the slip count before any further slip.
  always_comb begin
    boundary   = (bitcnt == BW'(WIDTH - 1));
    candidate  = {sr, D};
    is_match   = (candidate == PATTERN);
    last_phase = (slipcnt == BW'(WIDTH - 1));
  end

  // Single sequential block holding the FSM, the deserialiser and every
  // registered output.
  //
  // The shift register and bit counter advance on every cycle except a slip
  // cycle; holding them for one cycle throws away the bit on D and moves the
  // word boundary one bit later in the stream. CLEAR overrides that default
  // and zeroes the assembly state so the first HUNT cycle starts a fresh word.
  //
  // After a slip the next boundary is ignored: the word that follows a slip
  // is not compared, only the one after it. START from any state other than
  // CLEAR wins over a boundary in the same cycle, so no word is loaded and no
  // WORD_VALID pulse is issued on a restart edge. WORD itself is never
  // cleared on lock loss; only reset zeroes it.
  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= S_IDLE;
      sr         <= '0;
      bitcnt     <= '0;
      slipcnt    <= '0;
      matchcnt   <= '0;
      clrcnt     <= '0;
      skip       <= 1'b0;
      CD         <= 1'b0;
      WORD       <= '0;
      WORD_VALID <= 1'b0;
      LOCKED     <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      WORD_VALID <= 1'b0;

      if (state != S_SLIP) begin
        sr     <= candidate[WIDTH-2:0];
        bitcnt <= boundary ? '0 : bitcnt + BW'(1);
      end

      if (START && (state != S_CLEAR)) begin
        state  <= S_CLEAR;
        CD     <= 1'b1;
        clrcnt <= '0;
        LOCKED <= 1'b0;
        ERR    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
          end

          S_CLEAR: begin
            sr       <= '0;
            bitcnt   <= '0;
            slipcnt  <= '0;
            matchcnt <= '0;
            skip     <= 1'b0;
            LOCKED   <= 1'b0;
            ERR      <= 1'b0;
            if (clrcnt == CW'(CLR_CYCLES - 1)) begin
              CD    <= 1'b0;
              state <= S_HUNT;
            end else begin
              clrcnt <= clrcnt + CW'(1);
            end
          end

          S_HUNT: begin
            if (boundary) begin
              WORD <= candidate;
              if (skip) begin
                skip <= 1'b0;
              end else if (is_match) begin
                matchcnt <= MW'(1);
                if (LOCK_COUNT == 1) begin
                  state  <= S_LOCK;
                  LOCKED <= 1'b1;
                end else begin
                  state <= S_CONFIRM;
                end
              end else if (last_phase) begin
                state  <= S_FAIL;
                ERR    <= 1'b1;
                LOCKED <= 1'b0;
              end else begin
                state <= S_SLIP;
              end
            end
          end

          S_SLIP: begin
            slipcnt <= slipcnt + BW'(1);
            skip    <= 1'b1;
            state   <= S_HUNT;
          end

          S_CONFIRM: begin
            if (boundary) begin
              WORD <= candidate;
              if (is_match) begin
                matchcnt <= matchcnt + MW'(1);
                if (matchcnt == MW'(LOCK_COUNT - 1)) begin
                  state  <= S_LOCK;
                  LOCKED <= 1'b1;
                end
              end else begin
                matchcnt <= '0;
                if (last_phase) begin
                  state  <= S_FAIL;
                  ERR    <= 1'b1;
                  LOCKED <= 1'b0;
                end else begin
                  state <= S_SLIP;
                end
              end
            end
          end

          S_LOCK: begin
            if (boundary) begin
              WORD       <= candidate;
              WORD_VALID <= 1'b1;
            end
          end

          S_FAIL: begin
            LOCKED <= 1'b0;
            if (boundary) begin
              WORD <= candidate;
            end
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifs_align_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ifs_align_ctrl
//
// Self-checking bench for ifs_align_ctrl with the default parameters. A
// behavioural model tracks the lane as a queue of collected bits plus a few
// counters, and every cycle all outputs are compared against it. Directed
// scenarios cover reset, aligned and delayed training streams, the failure
// path, mid-confirm reset and restart while locked; randomised delays and
// random noise with random restarts follow.
// ---------------------------------------------------------------------------
module tb_ifs_align_ctrl;

  localparam int         W   = 8;
  localparam logic [7:0] PAT = 8'hA5;
  localparam int         LC  = 4;
  localparam int         CLR = 2;

  logic         SCLK;
  logic         RSTN;
  logic         START;
  logic         D;
  logic         CD;
  logic [W-1:0] WORD;
  logic         WORD_VALID;
  logic         LOCKED;
  logic         ERR;

  int checks = 0;
  int passed = 0;

  // Model state
  logic         cdM, lockedM, errM, wvM;
  logic [W-1:0] wordM;
  logic         idleM, slipNow, discardM;
  int           clrLeft, matchesM, slipsM;
  logic         bitsQ[$];

  // Position in the training stream being driven, and its leading delay
  int pos;
  int delay;

  ifs_align_ctrl #(
    .WIDTH(W), .PATTERN(PAT), .LOCK_COUNT(LC), .CLR_CYCLES(CLR)
  ) dut (
    .SCLK(SCLK), .RSTN(RSTN), .START(START), .D(D), .CD(CD),
    .WORD(WORD), .WORD_VALID(WORD_VALID), .LOCKED(LOCKED), .ERR(ERR)
  );

  // Free-running 10-unit clock
  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  // Single comparison point: counts it and reports a mismatch
  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic checkOutput();
    checkVal("cd", {31'd0, CD}, {31'd0, cdM});
    checkVal("locked", {31'd0, LOCKED}, {31'd0, lockedM});
    checkVal("err", {31'd0, ERR}, {31'd0, errM});
    checkVal("word_valid", {31'd0, WORD_VALID}, {31'd0, wvM});
    checkVal("word", {24'd0, WORD}, {24'd0, wordM});
  endtask

  task automatic modelReset();
    cdM = 0; lockedM = 0; errM = 0; wvM = 0; wordM = '0;
    idleM = 1; slipNow = 0; discardM = 0;
    clrLeft = 0; matchesM = 0; slipsM = 0;
    bitsQ.delete();
  endtask

  // One rising edge of the lane as seen from outside: bits pile up in a queue
  // and a full queue is one word; a slip throws one bit away and the word
  // after it is ignored.
  task automatic modelEdge(input logic st, input logic d);
    logic [W-1:0] w;
    wvM = 1'b0;
    if (clrLeft > 0) begin
      bitsQ.delete();
      slipsM = 0; matchesM = 0; lockedM = 0; errM = 0;
      discardM = 0; slipNow = 0;
      clrLeft--;
      cdM = (clrLeft > 0);
    end else if (st) begin
      idleM = 0; clrLeft = CLR; cdM = 1; lockedM = 0; errM = 0;
    end else if (idleM) begin
    end else if (slipNow) begin
      slipNow = 0; slipsM++; discardM = 1;
    end else begin
      bitsQ.push_back(d);
      if (bitsQ.size() == W) begin
        w = '0;
        foreach (bitsQ[i]) w = {w[W-2:0], bitsQ[i]};
        bitsQ.delete();
        wordM = w;
        if (lockedM) wvM = 1;
        else if (errM) begin end
        else if (discardM) discardM = 0;
        else if (w == PAT) begin
          matchesM++;
          if (matchesM == LC) lockedM = 1;
        end else begin
          matchesM = 0;
          if (slipsM == W - 1) errM = 1;
          else slipNow = 1;
        end
      end
    end
  endtask

  // One clock cycle: drive, clock, advance the model, compare
  task automatic applyStimulus(input logic st, input logic d);
    START = st;
    D     = d;
    @(posedge SCLK);
    modelEdge(st, d);
    #1;
    checkOutput();
  endtask

  function automatic logic streamBit(input int p, input int dl);
    logic [7:0] pv;
    pv = PAT;
    if (p < dl) return 1'b0;
    return pv[7 - ((p - dl) % 8)];
  endfunction

  task automatic nextStreamStep(input logic st);
    applyStimulus(st, streamBit(pos, delay));
    pos++;
  endtask

  // Two CLEAR cycles after a START edge: CD high for both, low afterwards
  task automatic clearPhase();
    checkVal("cd_start", {31'd0, CD}, 32'd1);
    applyStimulus(0, 0);
    checkVal("cd_clr1", {31'd0, CD}, 32'd1);
    applyStimulus(0, 0);
    checkVal("cd_clr2", {31'd0, CD}, 32'd0);
  endtask

  // Feed a training stream delayed by k bits until lock; k slips plus the
  // discarded word each cost 17 cycles, then four words to lock.
  task automatic lockPhase(input int k);
    int lockStep;
    lockStep = 0;
    pos = 0;
    delay = k;
    for (int n = 1; n <= 200; n++) begin
      nextStreamStep(0);
      if (LOCKED === 1'b1) begin
        lockStep = n;
        break;
      end
    end
    checkVal("lock_step", lockStep, 17 * k + 32);
  endtask

  task automatic pulseReset();
    #2 RSTN = 1'b0;
    #1;
    modelReset();
    checkVal("rst_cd", {31'd0, CD}, 32'd0);
    checkVal("rst_locked", {31'd0, LOCKED}, 32'd0);
    checkVal("rst_err", {31'd0, ERR}, 32'd0);
    checkVal("rst_wv", {31'd0, WORD_VALID}, 32'd0);
    checkVal("rst_word", {24'd0, WORD}, 32'd0);
    @(posedge SCLK);
    #1;
    checkOutput();
    #3 RSTN = 1'b1;
  endtask

  initial begin
    int k;
    RSTN = 1'b1; START = 1'b0; D = 1'b0;
    pos = 0; delay = 0;
    modelReset();

    // Reset asserted between edges, then idle with D toggling
    pulseReset();
    for (int i = 0; i < 20; i++) applyStimulus(0, i[0]);
    checkVal("idle_cd", {31'd0, CD}, 32'd0);

    // Aligned stream: lock on the 4th boundary, then payload every 8 cycles
    $display("[TB] aligned stream");
    applyStimulus(1, 0);
    clearPhase();
    lockPhase(0);
    for (int i = 0; i < 24; i++) nextStreamStep(0);

    // Restart while locked, on a boundary cycle
    $display("[TB] restart on boundary");
    for (int i = 0; i < W && bitsQ.size() != W - 1; i++) nextStreamStep(0);
    checkVal("pre_restart_fill", bitsQ.size(), W - 1);
    nextStreamStep(1);
    checkVal("restart_wv", {31'd0, WORD_VALID}, 32'd0);
    checkVal("restart_locked", {31'd0, LOCKED}, 32'd0);
    clearPhase();
    lockPhase(0);

    // Stream delayed by 3 bits
    $display("[TB] delayed stream k=3");
    applyStimulus(1, 0);
    clearPhase();
    lockPhase(3);

    // Constant zero: every phase fails
    $display("[TB] failure path");
    applyStimulus(1, 0);
    clearPhase();
    for (int i = 0; i < 126; i++) applyStimulus(0, 0);
    checkVal("err_before", {31'd0, ERR}, 32'd0);
    applyStimulus(0, 0);
    checkVal("err_set", {31'd0, ERR}, 32'd1);
    checkVal("err_locked", {31'd0, LOCKED}, 32'd0);
    for (int i = 0; i < 20; i++) applyStimulus(0, 1);
    checkVal("err_held", {31'd0, ERR}, 32'd1);
    applyStimulus(1, 0);
    checkVal("err_cleared", {31'd0, ERR}, 32'd0);
    clearPhase();

    // Reset in the middle of confirming (two words matched)
    $display("[TB] reset mid-confirm");
    applyStimulus(1, 0);
    clearPhase();
    pos = 0; delay = 0;
    for (int i = 0; i < 19; i++) nextStreamStep(0);
    pulseReset();
    for (int i = 0; i < 40; i++) nextStreamStep(0);
    checkVal("no_lock_after_rst", {31'd0, LOCKED}, 32'd0);

    // Random delays
    $display("[TB] random delays");
    for (int r = 0; r < 6; r++) begin
      k = $urandom_range(0, 7);
      applyStimulus(1, 0);
      clearPhase();
      lockPhase(k);
      for (int i = 0; i < 10; i++) nextStreamStep(0);
    end

    // Random noise with occasional restarts
    $display("[TB] random noise");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 40) == 0, $urandom % 2);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
